// File: rtl/pattern_1010_gen.sv
// pattern_1010_gen
//   Serial pattern transmitter. When a start request is accepted it sends
//   PATTERN on sout, MSB first, count times. GAP idle cycles (sout=0) are
//   inserted between repetitions. A one-cycle done pulse follows the last bit.
//
// Parameters
//   PAT_W   pattern length in bits (>= 2)
//   PATTERN bit pattern, transmitted MSB first
//   CNT_W   width of the repetition count
//   GAP     idle cycles between repetitions (0 = back-to-back)
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high
//   start  in   transfer request, sampled only in IDLE
//   count  in   repetitions, latched when start is accepted
//   abort  in   only with PATTERN_GEN_ABORT_EN defined: ends a transfer early
//   sout   out  serial data (registered)
//   sval   out  sout carries a pattern bit
//   busy   out  transfer in progress
//   done   out  one-cycle pulse after the transfer ends
//
// Build option
//   PATTERN_GEN_ABORT_EN  adds the abort input. Without it, transfers end
//                         only on completion or reset.

module pattern_1010_gen #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int unsigned      CNT_W   = 8,
    parameter int unsigned      GAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef PATTERN_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             sout,
    output logic             sval,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] rep_q,   rep_d;
    logic [GAP_W-1:0] gap_q,   gap_d;

    logic sout_q, sout_d;
    logic sval_q, sval_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic abort_req;

`ifdef PATTERN_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State register. The outputs are registered here too, so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d = S_SEND;
                        rep_d   = count;
                        idx_d   = IDX_LAST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_SEND: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    // Last bit of this repetition
                    rep_d = rep_q - REP_ONE;
                    if (rep_q == REP_ONE) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        idx_d = IDX_LAST;
                    end
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end

            S_GAP: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (gap_q == GAP_ONE) begin
                    state_d = S_SEND;
                    idx_d   = IDX_LAST;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                rep_d   = '0;
                gap_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode. It uses the next state so that each registered output
    // matches the state that is entered on the same edge.
    always_comb begin
        sout_d = 1'b0;
        sval_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;

        unique case (state_d)
            S_SEND: begin
                sout_d = PATTERN[idx_d];
                sval_d = 1'b1;
                busy_d = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                sout_d = 1'b0;
            end
        endcase
    end

    assign sout = sout_q;
    assign sval = sval_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pattern_1010_gen.sv
// tb_pattern_1010_gen
//   Bench for pattern_1010_gen. It uses two instances:
//     index 0: GAP=2 (gapped repetitions)
//     index 1: GAP=0 (back-to-back repetitions)
//   Each pattern bit and each transfer summary (bit count, busy length,
//   done cycle) is queued when the stimulus is issued. A negedge monitor
//   pops these and compares them with what each DUT presents.

module tb_pattern_1010_gen;

    localparam int unsigned GAP_A = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [7:0] count;
    logic [1:0] sout, sval, busy, done;

    always #5 clk = ~clk;

    pattern_1010_gen #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8), .GAP(GAP_A)) u_gap (
        .clk   (clk),
        .reset (reset),
        .start (start[0]),
        .count (count),
        .sout  (sout[0]),
        .sval  (sval[0]),
        .busy  (busy[0]),
        .done  (done[0])
    );

    pattern_1010_gen #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8), .GAP(0)) u_b2b (
        .clk   (clk),
        .reset (reset),
        .start (start[1]),
        .count (count),
        .sout  (sout[1]),
        .sval  (sval[1]),
        .busy  (busy[1]),
        .done  (done[1])
    );

    typedef struct {
        int nbits;
        int nbusy;
        int dcyc;
    } rec_t;

    int   exp_bits [2][$];
    rec_t recs     [2][$];
    int   seen_bits [2];
    int   seen_busy [2];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expectations whenever a DUT presents a bit or a done.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                seen_bits[d] = 0;
                seen_busy[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (sval[d]) begin
                    chk($sformatf("dut%0d_sval_busy", d), int'(busy[d]), 1);
                    chk($sformatf("dut%0d_bit_expected", d), int'(exp_bits[d].size() != 0), 1);
                    if (exp_bits[d].size() != 0)
                        chk($sformatf("dut%0d_sout", d), int'(sout[d]), exp_bits[d].pop_front());
                    seen_bits[d]++;
                end else begin
                    chk($sformatf("dut%0d_sout_idle", d), int'(sout[d]), 0);
                end
                if (busy[d]) seen_busy[d]++;
                if (done[d]) begin
                    chk($sformatf("dut%0d_done_expected", d), int'(recs[d].size() != 0), 1);
                    chk($sformatf("dut%0d_busy_at_done", d), int'(busy[d]), 0);
                    if (recs[d].size() != 0) begin
                        rec_t r;
                        r = recs[d].pop_front();
                        chk($sformatf("dut%0d_xfer_bits", d), seen_bits[d], r.nbits);
                        chk($sformatf("dut%0d_xfer_busy", d), seen_busy[d], r.nbusy);
                        chk($sformatf("dut%0d_done_cycle", d), cyc, r.dcyc);
                    end
                    seen_bits[d] = 0;
                    seen_busy[d] = 0;
                end
            end
        end
    end

    // Queue the expected response for n reps of 1010 that are accepted at edge e.
    task automatic push_xfer(input int d, input int n, input int e, output int l);
        int g;
        g = (d == 0) ? int'(GAP_A) : 0;
        l = (n > 0) ? (n * 4 + (n - 1) * g) : 0;
        for (int r = 0; r < n; r++) begin
            exp_bits[d].push_back(1);
            exp_bits[d].push_back(0);
            exp_bits[d].push_back(1);
            exp_bits[d].push_back(0);
        end
        recs[d].push_back('{n * 4, l, e + l});
    endtask

    // Single transfer. It returns just after the edge that leaves DONE, so the
    // DUT is in IDLE.
    task automatic run(input int d, input int n);
        int e, l;
        @(posedge clk); #1;
        count    = n[7:0];
        start[d] = 1'b1;
        e = cyc + 1;
        push_xfer(d, n, e, l);
        @(posedge clk); #1;
        start[d] = 1'b0;
        repeat (l + 1) @(posedge clk);
    endtask

    initial begin
        int e, l, e2, l2;

        reset = 1'b0;
        start = '0;
        count = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_reset_sout", d), int'(sout[d]), 0);
            chk($sformatf("dut%0d_reset_sval", d), int'(sval[d]), 0);
            chk($sformatf("dut%0d_reset_busy", d), int'(busy[d]), 0);
            chk($sformatf("dut%0d_reset_done", d), int'(done[d]), 0);
        end
        @(negedge clk); #1 reset = 1'b0;

        // Gapped instance: single, multi-rep, and zero count
        run(0, 1);
        run(0, 3);
        run(0, 0);

        // Start is held for the whole count=2 transfer and through DONE.
        // count changes after acceptance. The next acceptance must take
        // place two edges after the DONE cycle starts, with count=1.
        @(posedge clk); #1;
        count    = 8'd2;
        start[0] = 1'b1;
        e = cyc + 1;
        push_xfer(0, 2, e, l);
        @(posedge clk); #1;
        count = 8'd1;
        e2 = e + l + 2;
        push_xfer(0, 1, e2, l2);
        repeat (e2 - cyc) @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (l2 + 1) @(posedge clk);

        // Back-to-back instance, including the maximum count
        run(1, 3);
        run(1, 1);
        run(1, 255);

        // Reset is asserted during the 3rd bit of a count=4 transfer.
        // Only two bits are seen before the outputs clear.
        @(posedge clk); #1;
        count    = 8'd4;
        start[0] = 1'b1;
        exp_bits[0].push_back(1);
        exp_bits[0].push_back(0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dut0_pre_reset_sval", int'(sval[0]), 1);
        chk("dut0_pre_reset_sout", int'(sout[0]), 1);
        reset = 1'b1;
        #1;
        chk("dut0_midreset_sout", int'(sout[0]), 0);
        chk("dut0_midreset_sval", int'(sval[0]), 0);
        chk("dut0_midreset_busy", int'(busy[0]), 0);
        chk("dut0_midreset_done", int'(done[0]), 0);
        @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        run(0, 1);

        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_bits_left", d), exp_bits[d].size(), 0);
            chk($sformatf("dut%0d_recs_left", d), recs[d].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_1010_gen.md
# pattern_1010_gen

Serial pattern transmitter: the sending end of the 1010 sequence-detection link. On a start request it emits a fixed bit pattern (default 1010, MSB first) on a single serial line, a programmable number of times, with optional idle gaps between repetitions. It feeds the serial input of the 1010 detector in loopback benches and drives pattern traffic in system tests. It runs on the same clock as the detector.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b1010, pattern transmitted MSB first
- CNT_W, 8, width of repetition count
- GAP, 0, idle cycles (sout=0) inserted between consecutive repetitions; 0 = back-to-back
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- start  input  1  request; sampled only in IDLE
- count  input  CNT_W  repetitions; latched when start is accepted
- sout  output  1  serial data (registered)
- sval  output  1  high in cycles where sout carries a pattern bit (not gap/idle)
- busy  output  1  high from the cycle after acceptance through the last pattern bit
- done  output  1  one-cycle pulse after the transfer completes
- abort  input  1  present only with PATTERN_GEN_ABORT_EN (see Configuration)

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: sout=0, sval=0, busy=0. At an edge with start=1 and count≠0, latch count into rep counter, load bit index PAT_W-1, go to SEND. If start=1 and count=0, go to DONE directly (no bits sent).
- SEND: sout=PATTERN[idx], sval=1, busy=1. Each cycle idx decrements. At idx=0: decrement rep counter. If reps remain, go to GAP (GAP>0) or reload idx=PAT_W-1 and stay in SEND (GAP=0). If none remain, go to DONE.
- GAP: sout=0, sval=0, busy=1 for exactly GAP cycles (gap counter width $clog2(GAP+1)), then SEND with idx=PAT_W-1.
- DONE: done=1, busy=0, sout=0 for one cycle, then IDLE. A start in DONE is ignored.
- start while busy or in DONE: ignored, not queued. count changes after acceptance have no effect.
- Rep counter is CNT_W bits; max transfer is 2^CNT_W−1 repetitions; no wrap.
- All outputs registered (Moore); no combinational path from any input to any output.

## Timing
- Reset: state IDLE, sout=0, sval=0, busy=0, done=0, all counters 0; effective immediately (asynchronous), including mid-transfer; a partial pattern is simply truncated.
- Latency: start accepted at edge E → first pattern bit on sout in the cycle after E (busy and sval rise together).
- Transfer length for N reps: N·PAT_W + (N−1)·GAP cycles of busy; done pulses in the following cycle.
- count=0: done pulses in the cycle after E; busy and sval never rise.
- Earliest next start: the edge ending the DONE cycle is ignored; next start accepted at the following edge (IDLE).

## Configuration
- PATTERN_GEN_ABORT_EN defined: abort input exists. abort=1 sampled in SEND or GAP forces DONE at the next edge (sout=0, sval=0 immediately in DONE); done still pulses once; abort in IDLE/DONE ignored; abort and start together in IDLE: start wins.
- Undefined: no abort port; transfers always run to completion or reset.

## Test plan
- Reset then start=1, count=1, GAP=0 → sout 1,0,1,0 in 4 cycles after acceptance, sval=1 for those 4, done pulse in cycle 5, busy low in cycle 5.
- count=3, GAP=2 → sout 1010 00 1010 00 1010, sval=0 during gaps, busy=1 for 16 cycles, single done; looped into the 1010 detector → exactly 3 q pulses.
- count=0 with start → done one cycle later, sout/sval/busy stay 0.
- start re-asserted every cycle during a count=2 transfer → exactly 8 pattern bits, one done; start held through DONE → new transfer begins one cycle after DONE.
- reset asserted after the 2nd bit of a count=4 transfer → all outputs 0 immediately, IDLE; next start=1, count=1 produces clean 1010.
- With PATTERN_GEN_ABORT_EN, abort in the 3rd bit of count=2 → DONE next edge, done pulse, total sval cycles = 3.
